// File: rtl/wb_arbiter_rr2.sv
// wb_arbiter_rr2 -- two-master, one-slave Wishbone B3 arbiter.
//
// Round-robin arbitration. The grant is held for as long as the owner keeps
// cyc high, so a burst is never split. A stall watchdog ends a transfer that
// the slave never acks by raising err toward the owner for one cycle.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   mN_*_i (N=0,1)             master request side (adr/dat/sel/we/cyc/stb/cti)
//   mN_dat_o/ack_o/err_o       master response side (ack/err to owner only)
//   s_*_o                      slave request side, muxed from the owner
//   s_dat_i/ack_i/err_i        slave response side
module wb_arbiter_rr2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic [2:0]      s_cti_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  // Counter is at least 8 bits and grows only when TIMEOUT needs it.
  localparam int CW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    r_grant, w_grant_nxt;
  logic          r_last,  w_last_nxt;
  logic [CW-1:0] r_wd_cnt;
  logic          w_own0, w_own1, w_own_cyc, w_own_stb, w_wd_err;

  assign w_own0    = (r_grant == OWN0);
  assign w_own1    = (r_grant == OWN1);
  assign w_own_cyc = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
  assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

  // A same-cycle ack beats the timeout.
  assign w_wd_err = (TIMEOUT != 0) && (w_own0 || w_own1) &&
                    (r_wd_cnt == CW'(TIMEOUT)) && !s_ack_i;

  // Next owner. From an OWN state a release hands straight to a waiting
  // master, so there is no idle bubble between back-to-back owners.
  always_comb begin
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_grant)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_grant_nxt = r_last ? OWN0 : OWN1;
        else if (m0_cyc_i)        w_grant_nxt = OWN0;
        else if (m1_cyc_i)        w_grant_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) w_grant_nxt = m1_cyc_i ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!m1_cyc_i) w_grant_nxt = m0_cyc_i ? OWN0 : IDLE;
      end
      default: w_grant_nxt = IDLE;
    endcase
    if (w_grant_nxt == OWN0 && r_grant != OWN0) w_last_nxt = 1'b0;
    if (w_grant_nxt == OWN1 && r_grant != OWN1) w_last_nxt = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_grant  <= IDLE;
      r_last   <= 1'b1;
      r_wd_cnt <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      if (TIMEOUT == 0 || w_grant_nxt != r_grant || s_ack_i || s_err_i || w_wd_err)
        r_wd_cnt <= '0;
      else if (w_own_cyc && w_own_stb)
        r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  // Slave side follows the registered grant only: no combinational path
  // from a master's cyc to s_cyc_o while idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (r_grant)
      OWN0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cti_o = m0_cti_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~w_wd_err;
      end
      OWN1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cti_o = m1_cti_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~w_wd_err;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & w_own0;
  assign m1_ack_o = s_ack_i & w_own1;
  assign m0_err_o = (s_err_i | w_wd_err) & w_own0;
  assign m1_err_o = (s_err_i | w_wd_err) & w_own1;

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Testbench for wb_arbiter_rr2: directed stimulus; expected master-side
// responses are queued by the stimulus and consumed by a separate monitor.
module tb_wb_arbiter_rr2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0, rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
  logic [DW-1:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat;
  logic [3:0]    m0_sel, m1_sel, s_sel_o;
  logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [2:0]    m0_cti, m1_cti, s_cti_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack, s_err;

  typedef struct packed {
    logic [3:0]  f;     // {m0_ack, m0_err, m1_ack, m1_err}
    logic [31:0] d;
    logic        chk_d;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  wb_arbiter_rr2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] f, input logic [31:0] d, input logic cd);
    exp_t e;
    e.f = f; e.d = d; e.chk_d = cd;
    exp_q.push_back(e);
  endtask

  // Monitor: any ack/err toward a master must match the head of the queue.
  initial begin
    logic [3:0] fl;
    exp_t e;
    forever begin
      @(negedge clk);
      fl = {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
      if (fl != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: got flags %b expected none", fl);
        end else begin
          e = exp_q.pop_front();
          chk("resp_flags", {28'd0, fl}, {28'd0, e.f});
          if (e.chk_d) chk("resp_data", (fl[3] | fl[2]) ? m0_dat_o : m1_dat_o, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    m0_adr = '0; m0_dat = 32'h0A0A_0A0A; m0_sel = 4'hF; m0_we = 1'b0; m0_cti = 3'b000;
    m1_adr = '0; m1_dat = 32'h1B1B_1B1B; m1_sel = 4'hF; m1_we = 1'b0; m1_cti = 3'b000;
    // 1: reset with both masters requesting and the slave answering
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    s_dat = 32'h0; s_ack = 1'b1; s_err = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
      chk("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
      chk("rst_resp", {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
    end
    rst = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0;

    // 2: m0 read of 0x100, ack two cycles after strobe
    tick();
    m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_adr", s_adr_o, 32'h100);
    chk("t2_stb", {31'd0, s_stb_o}, 32'd1);
    tick();
    tick();
    push(4'b1000, 32'hDEAD_BEEF, 1'b1);
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

    // 3: simultaneous request after reset, handover, round-robin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_adr = 32'h200; m1_adr = 32'h300;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_first_m0", s_adr_o, 32'h200);
    tick();
    push(4'b1000, 32'h11, 1'b1);
    s_ack = 1'b1; s_dat = 32'h11;
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_handover_adr", s_adr_o, 32'h300);
    chk("t3_handover_cyc", {31'd0, s_cyc_o}, 32'd1);
    tick();
    push(4'b0010, 32'h22, 1'b1);
    s_ack = 1'b1; s_dat = 32'h22;
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_rr_m0", s_adr_o, 32'h200);
    tick();
    push(4'b1000, 32'h33, 1'b1);
    s_ack = 1'b1; s_dat = 32'h33;
    tick();
    s_ack = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

    // 4: m0 4-beat burst while m1 waits
    tick();
    m0_adr = 32'h400; m1_adr = 32'h500; m0_cti = 3'b010;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_cti = (i == 3) ? 3'b111 : 3'b010;
      push(4'b1000, 32'hA0 + i, 1'b1);
      s_ack = 1'b1; s_dat = 32'hA0 + i;
      @(negedge clk);
      chk("t4_cti", {29'd0, s_cti_o}, (i == 3) ? 32'd7 : 32'd2);
      chk("t4_adr", s_adr_o, 32'h400);
      tick();
    end
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = 3'b000;
    @(negedge clk);
    chk("t4_hold_m0", s_adr_o, 32'h400);

    // 5: m1 stalls; watchdog fires after 8 strobe cycles, then restarts
    tick();
    @(negedge clk);
    chk("t4_m1_granted", s_adr_o, 32'h500);
    chk("t5_stb_s1", {31'd0, s_stb_o}, 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      @(negedge clk);
      chk("t5_stb_stall", {31'd0, s_stb_o}, 32'd1);
    end
    tick();
    push(4'b0001, 32'h0, 1'b0);
    @(negedge clk);
    chk("t5_stb_gated", {31'd0, s_stb_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_stb_restart", {31'd0, s_stb_o}, 32'd1);
    for (int k = 11; k <= 17; k++) tick();
    tick();
    push(4'b0001, 32'h0, 1'b0);
    @(negedge clk);
    chk("t5_stb_gated2", {31'd0, s_stb_o}, 32'd0);

    // 6: reset during the stalled m1 transfer
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pre_rst_cyc", {31'd0, s_cyc_o}, 32'd1);
    tick();
    rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1; s_dat = 32'h55;
    @(negedge clk);
    chk("t6_post_rst_cyc", {31'd0, s_cyc_o}, 32'd0);
    tick();
    s_ack = 1'b0;
    @(negedge clk);
    chk("t6_m0_first", s_adr_o, 32'h400);
    tick();
    push(4'b1000, 32'h77, 1'b1);
    s_ack = 1'b1; s_dat = 32'h77;
    tick();
    s_ack = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("final_idle_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
